// File: rtl/led_sweep_monitor.sv
// ============================================================================
// led_sweep_monitor : tracks a single lit LED sweeping back and forth
// Rev 1.0
// ============================================================================
`default_nettype none

module led_sweep_monitor #(
  parameter int N     = 8,
  parameter int CNT_W = 16
) (
  input  logic                 divided_clock,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [N-1:0]         led_in,
  output logic [$clog2(N)-1:0] pos,
  output logic                 dir,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [CNT_W-1:0]     err_count,
  output logic [CNT_W-1:0]     bounce_count
);

  localparam int PW = $clog2(N);
  localparam logic [PW-1:0] C_LAST = PW'(N - 1);
  localparam logic [PW-1:0] C_PRE_LAST = PW'(N - 2);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEEK   = 2'd1,
    S_ANCHOR = 2'd2,
    S_TRACK  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    pos_q, pos_d;
  logic             dir_q, dir_d;
  logic             locked_q;
  logic             err_pulse_q, err_pulse_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] bnc_cnt_q, bnc_cnt_d;

  logic             sample_valid;
  logic [PW-1:0]    sample_idx;
  logic [PW-1:0]    expected_idx;
  logic             adjacent;

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero
  assign sample_valid = (led_in != '0) && ((led_in & (led_in - 1'b1)) == '0);

  always_comb begin
    sample_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (led_in[i]) sample_idx = PW'(i);
    end
  end

  // Widened by one bit so pos+1 at the top end cannot alias to zero
  assign adjacent = ({1'b0, sample_idx} == {1'b0, pos_q} + 1'b1) ||
                    ({1'b0, pos_q} == {1'b0, sample_idx} + 1'b1);

  always_comb begin
    if (pos_q == C_LAST)    expected_idx = C_PRE_LAST;
    else if (pos_q == '0)   expected_idx = PW'(1);
    else if (dir_q)         expected_idx = pos_q + 1'b1;
    else                    expected_idx = pos_q - 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    dir_d       = dir_q;
    err_pulse_d = 1'b0;
    err_cnt_d   = err_cnt_q;
    bnc_cnt_d   = bnc_cnt_q;

    if (!enable) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_SEEK: begin
          if (sample_valid) begin
            pos_d   = sample_idx;
            state_d = S_ANCHOR;
          end else begin
            state_d = S_SEEK;
          end
        end
        S_ANCHOR: begin
          if (!sample_valid) begin
            state_d = S_SEEK;
          end else if (adjacent) begin
            dir_d   = (sample_idx > pos_q);
            pos_d   = sample_idx;
            state_d = S_TRACK;
          end else begin
            pos_d   = sample_idx;
          end
        end
        S_TRACK: begin
          if (sample_valid && (sample_idx == expected_idx)) begin
            pos_d = sample_idx;
            if ((pos_q == '0) || (pos_q == C_LAST)) begin
              dir_d = ~dir_q;
              if (bnc_cnt_q != '1) bnc_cnt_d = bnc_cnt_q + 1'b1;
            end
          end else begin
            err_pulse_d = 1'b1;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
            if (sample_valid) begin
              pos_d   = sample_idx;
              state_d = S_ANCHOR;
            end else begin
              state_d = S_SEEK;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge divided_clock or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pos_q       <= '0;
      dir_q       <= 1'b0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
      bnc_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      dir_q       <= dir_d;
      locked_q    <= (state_d == S_TRACK);
      err_pulse_q <= err_pulse_d;
      err_cnt_q   <= err_cnt_d;
      bnc_cnt_q   <= bnc_cnt_d;
    end
  end

  assign pos          = pos_q;
  assign dir          = dir_q;
  assign locked       = locked_q;
  assign err_pulse    = err_pulse_q;
  assign err_count    = err_cnt_q;
  assign bounce_count = bnc_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_led_sweep_monitor.sv
// ============================================================================
// tb_led_sweep_monitor : directed table, corner sequences and random model check
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_led_sweep_monitor;

  logic        divided_clock = 1'b0;
  logic        rst;
  logic        enable;
  logic [7:0]  led_in;

  logic [2:0]  pos_w, pos_s;
  logic        dir_w, dir_s, lck_w, lck_s, pls_w, pls_s;
  logic [15:0] err_w, bnc_w;
  logic [1:0]  err_s, bnc_s;

  int checks = 0;
  int errors = 0;

  always #5 divided_clock = ~divided_clock;

  led_sweep_monitor #(.N(8), .CNT_W(16)) u_dut (
    .divided_clock(divided_clock), .rst(rst), .enable(enable), .led_in(led_in),
    .pos(pos_w), .dir(dir_w), .locked(lck_w), .err_pulse(pls_w),
    .err_count(err_w), .bounce_count(bnc_w)
  );

  led_sweep_monitor #(.N(8), .CNT_W(2)) u_sat (
    .divided_clock(divided_clock), .rst(rst), .enable(enable), .led_in(led_in),
    .pos(pos_s), .dir(dir_s), .locked(lck_s), .err_pulse(pls_s),
    .err_count(err_s), .bounce_count(bnc_s)
  );

  typedef struct {
    logic       en;
    logic [7:0] led;
    logic [2:0] pos;
    logic       dir;
    logic       lck;
    logic       pls;
    int         err;
    int         bnc;
  } vec_t;

  vec_t tbl[26];

  // Reference model state: stage 0 = not anchored, 1 = anchor held, 2 = tracking
  int m_stage, m_pos, m_dir, m_err, m_bnc, m_pulse;

  function automatic int sat3(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  function automatic logic [63:0] pack(input logic [2:0] p, input logic d, input logic l,
                                       input logic s, input int e, input int b);
    return {26'd0, p, d, l, s, e[15:0], b[15:0]};
  endfunction

  function automatic int next_expected(input int p, input int d);
    if (p == 7) return 6;
    if (p == 0) return 1;
    return d ? p + 1 : p - 1;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (pos,dir,lck,pls,err,bnc)", name, got, exp);
    end
  endtask

  task automatic check_both(input string name, input logic [2:0] p, input logic d,
                            input logic l, input logic s, input int e, input int b);
    check({name, "_w"}, pack(pos_w, dir_w, lck_w, pls_w, int'(err_w), int'(bnc_w)),
          pack(p, d, l, s, e, b));
    check({name, "_s"}, pack(pos_s, dir_s, lck_s, pls_s, int'(err_s), int'(bnc_s)),
          pack(p, d, l, s, sat3(e), sat3(b)));
  endtask

  task automatic model_reset();
    m_stage = 0; m_pos = 0; m_dir = 0; m_err = 0; m_bnc = 0; m_pulse = 0;
  endtask

  task automatic model_step(input logic en, input logic [7:0] led);
    int idx;
    bit valid;
    valid = ($countones(led) == 1);
    idx = 0;
    for (int i = 0; i < 8; i++) if (led[i]) idx = i;
    m_pulse = 0;
    if (!en) begin
      m_stage = 0;
    end else if (m_stage == 0) begin
      if (valid) begin m_pos = idx; m_stage = 1; end
    end else if (m_stage == 1) begin
      if (!valid) m_stage = 0;
      else if (idx - m_pos == 1 || m_pos - idx == 1) begin
        m_dir = (idx > m_pos) ? 1 : 0; m_pos = idx; m_stage = 2;
      end else m_pos = idx;
    end else begin
      if (valid && idx == next_expected(m_pos, m_dir)) begin
        if (m_pos == 0 || m_pos == 7) begin m_dir = 1 - m_dir; m_bnc++; end
        m_pos = idx;
      end else begin
        m_pulse = 1; m_err++;
        if (valid) begin m_pos = idx; m_stage = 1; end
        else m_stage = 0;
      end
    end
  endtask

  task automatic edge_then_sample();
    @(posedge divided_clock);
    #1;
  endtask

  initial begin
    //             en    led          pos   dir   lck   pls  err bnc
    tbl[0]  = '{1'b1, 8'b0000_1000, 3'd3, 1'b0, 1'b0, 1'b0, 0, 0};
    tbl[1]  = '{1'b1, 8'b0000_0100, 3'd2, 1'b0, 1'b1, 1'b0, 0, 0};
    tbl[2]  = '{1'b1, 8'b0000_0010, 3'd1, 1'b0, 1'b1, 1'b0, 0, 0};
    tbl[3]  = '{1'b1, 8'b0000_0001, 3'd0, 1'b0, 1'b1, 1'b0, 0, 0};
    tbl[4]  = '{1'b1, 8'b0000_0010, 3'd1, 1'b1, 1'b1, 1'b0, 0, 1};
    tbl[5]  = '{1'b1, 8'b0000_0100, 3'd2, 1'b1, 1'b1, 1'b0, 0, 1};
    tbl[6]  = '{1'b1, 8'b0000_1000, 3'd3, 1'b1, 1'b1, 1'b0, 0, 1};
    tbl[7]  = '{1'b1, 8'b0010_0000, 3'd5, 1'b1, 1'b0, 1'b1, 1, 1};
    tbl[8]  = '{1'b1, 8'b0100_0000, 3'd6, 1'b1, 1'b1, 1'b0, 1, 1};
    tbl[9]  = '{1'b1, 8'b1000_0000, 3'd7, 1'b1, 1'b1, 1'b0, 1, 1};
    tbl[10] = '{1'b1, 8'b0100_0000, 3'd6, 1'b0, 1'b1, 1'b0, 1, 2};
    tbl[11] = '{1'b1, 8'b0000_0000, 3'd6, 1'b0, 1'b0, 1'b1, 2, 2};
    tbl[12] = '{1'b1, 8'b0000_0100, 3'd2, 1'b0, 1'b0, 1'b0, 2, 2};
    tbl[13] = '{1'b1, 8'b0000_1000, 3'd3, 1'b1, 1'b1, 1'b0, 2, 2};
    tbl[14] = '{1'b1, 8'b0001_1000, 3'd3, 1'b1, 1'b0, 1'b1, 3, 2};
    tbl[15] = '{1'b1, 8'b0001_0000, 3'd4, 1'b1, 1'b0, 1'b0, 3, 2};
    tbl[16] = '{1'b1, 8'b0100_0000, 3'd6, 1'b1, 1'b0, 1'b0, 3, 2};
    tbl[17] = '{1'b1, 8'b0010_0000, 3'd5, 1'b0, 1'b1, 1'b0, 3, 2};
    tbl[18] = '{1'b0, 8'b0000_0001, 3'd5, 1'b0, 1'b0, 1'b0, 3, 2};
    tbl[19] = '{1'b0, 8'b0000_0000, 3'd5, 1'b0, 1'b0, 1'b0, 3, 2};
    tbl[20] = '{1'b1, 8'b0000_0001, 3'd0, 1'b0, 1'b0, 1'b0, 3, 2};
    tbl[21] = '{1'b1, 8'b0000_0010, 3'd1, 1'b1, 1'b1, 1'b0, 3, 2};
    tbl[22] = '{1'b1, 8'b0000_0000, 3'd1, 1'b1, 1'b0, 1'b1, 4, 2};
    tbl[23] = '{1'b1, 8'b0000_0001, 3'd0, 1'b1, 1'b0, 1'b0, 4, 2};
    tbl[24] = '{1'b1, 8'b0000_0010, 3'd1, 1'b1, 1'b1, 1'b0, 4, 2};
    tbl[25] = '{1'b1, 8'b1000_0001, 3'd1, 1'b1, 1'b0, 1'b1, 5, 2};

    rst = 1'b1; enable = 1'b0; led_in = 8'h00;
    #2;
    check_both("reset_async", 3'd0, 1'b0, 1'b0, 1'b0, 0, 0);
    edge_then_sample();
    rst = 1'b0;

    for (int i = 0; i < 26; i++) begin
      enable = tbl[i].en;
      led_in = tbl[i].led;
      edge_then_sample();
      check_both($sformatf("row%0d", i), tbl[i].pos, tbl[i].dir, tbl[i].lck,
                 tbl[i].pls, tbl[i].err, tbl[i].bnc);
    end

    // Lock at pos 3 going up, then reset between edges
    enable = 1'b1; led_in = 8'b0000_0100; edge_then_sample();
    led_in = 8'b0000_1000; edge_then_sample();
    check_both("prelock", 3'd3, 1'b1, 1'b1, 1'b0, 5, 2);
    #2 rst = 1'b1;
    #1 check_both("rst_midtrack", 3'd0, 1'b0, 1'b0, 1'b0, 0, 0);
    rst = 1'b0;
    // 4 would continue the old sweep; after reset it must only anchor
    led_in = 8'b0001_0000; edge_then_sample();
    check_both("reacq_anchor", 3'd4, 1'b0, 1'b0, 1'b0, 0, 0);
    led_in = 8'b0010_0000; edge_then_sample();
    check_both("reacq_lock", 3'd5, 1'b1, 1'b1, 1'b0, 0, 0);

    #2 rst = 1'b1;
    #1 rst = 1'b0;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      int r, tgt;
      enable = ($urandom_range(0, 15) != 0);
      r = $urandom_range(0, 9);
      if (r < 6) begin
        if (m_stage == 2) tgt = next_expected(m_pos, m_dir);
        else if (m_stage == 1) tgt = (m_pos == 7) ? 6 : ((m_pos == 0) ? 1 : m_pos + (($urandom_range(0, 1) != 0) ? 1 : -1));
        else tgt = $urandom_range(0, 7);
        led_in = 8'd1 << tgt;
      end else if (r < 8) begin
        led_in = 8'd1 << $urandom_range(0, 7);
      end else if (r == 8) begin
        led_in = 8'h00;
      end else begin
        led_in = 8'($urandom);
      end
      model_step(enable, led_in);
      edge_then_sample();
      check_both($sformatf("rand%0d", c), 3'(m_pos), m_dir[0], (m_stage == 2),
                 m_pulse[0], m_err, m_bnc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
